// File: rtl/tick_pkg.sv
// Shared types and default constants for the seconds-tick controller.
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DEFAULT_CLK_HZ          = 50_000_000;
    localparam int DEFAULT_TICK_HZ         = 1;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, debounce filter and press event.
// The debounce filter exists only when SEC_TICK_DEBOUNCE_EN is defined.
module key_debounce
    import tick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;
    logic r_level_q;
    logic r_press;
    logic w_level;

    // Released key is 1, so every flop resets to the idle level and no event fires on exit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level_q <= 1'b1;
            r_press   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample its predecessor's old value.
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_level_q <= w_level;
            r_press   <= r_level_q & ~w_level;
        end
    end

`ifdef SEC_TICK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_db_cnt;
    logic          r_level;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b1;
        end else if (r_sync2 != r_level) begin
            if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    assign o_press = r_press;

endmodule

// File: rtl/sec_tick_ctrl.sv
// Start/pause/halt controller producing a one-cycle Enable strobe at TICK_HZ.
// Define SEC_TICK_DEBOUNCE_EN to build the key debounce filter.
module sec_tick_ctrl
    import tick_pkg::*;
#(
    parameter int CLK_HZ          = DEFAULT_CLK_HZ,
    parameter int TICK_HZ         = DEFAULT_TICK_HZ,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyN,
    input  logic Halt,
    output logic Enable,
    output logic Running
);

    localparam int            DIV        = CLK_HZ / TICK_HZ;
    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("sec_tick_ctrl: CLK_HZ / TICK_HZ must be at least 2");
    end

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic          r_enable;
    logic          w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .i_clk  (Clock),
        .i_rst  (Reset),
        .i_key_n(KeyN),
        .o_press(w_press)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Halt outranks a coincident press event.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        if (Halt) begin
            w_next = IDLE;
        end else if (w_press) begin
            case (r_state)
                IDLE:    w_next = RUN;
                RUN:     w_next = PAUSE;
                PAUSE:   w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    // Held at zero in IDLE so entering RUN always starts a full period; frozen in PAUSE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (Halt || (r_state == IDLE)) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    // The wrap cycle's pulse survives a coincident press but not a coincident Halt.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_enable <= 1'b0;
        end else begin
            r_enable <= !Halt && (r_state == RUN) && (r_presc == PRESC_LAST);
        end
    end

    assign Enable  = r_enable;
    assign Running = (r_state == RUN);

endmodule

// File: tb/tb_sec_tick_ctrl.sv
// Directed bench for sec_tick_ctrl with DIV=10 and DEBOUNCE_CYCLES=4.
// Expectations follow SEC_TICK_DEBOUNCE_EN: press event latency is 7 cycles with it, 3 without.
module tb_sec_tick_ctrl;
    import tick_pkg::*;

`ifdef SEC_TICK_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = 8;

    logic Clock;
    logic Reset;
    logic KeyN;
    logic Halt;
    logic Enable;
    logic Running;

    int vectors;
    int miscompares;
    int key_hold;

    sec_tick_ctrl #(
        .CLK_HZ         (10),
        .TICK_HZ        (1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .KeyN   (KeyN),
        .Halt   (Halt),
        .Enable (Enable),
        .Running(Running)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance one cycle, landing 1 ns after the edge; releases a held key when its time is up.
    task automatic tick();
        @(posedge Clock);
        #1;
        if (key_hold > 0) begin
            key_hold--;
            if (key_hold == 0) KeyN = 1'b1;
        end
    endtask

    task automatic press_start();
        KeyN     = 1'b0;
        key_hold = HOLD;
    endtask

    task automatic wait_running(input logic lvl, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (Running === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; KeyN = 1'b1; Halt = 1'b0; key_hold = 0;
        tick(); tick(); tick();
        vectors++;
        if (Running !== 1'b0 || Enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: Running=%b Enable=%b expected 0 0", Running, Enable);
        end
        vectors++;
        if (dut.r_presc !== 4'd0 || dut.r_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: presc=%0d state=%0d expected 0 %0d",
                     dut.r_presc, int'(dut.r_state), int'(IDLE));
        end
        Reset = 1'b0;
    endtask

    task automatic test_run();
        int  n;
        logic exp_en;
        press_start();
        wait_running(1'b1, 20, n);
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("FAIL run_start_latency: got %0d cycles, expected %0d", n, LAT + 1);
        end
        for (int j = 1; j <= 30; j++) begin
            tick();
            exp_en = (j % 10 == 0);
            vectors++;
            if (Enable !== exp_en) begin
                miscompares++;
                $display("FAIL run_enable[%0d]: Enable=%b expected %b", j, Enable, exp_en);
            end
        end
        vectors++;
        if (Running !== 1'b1) begin
            miscompares++;
            $display("FAIL run_running: Running=%b expected 1", Running);
        end
    endtask

    // Pause so the prescaler freezes at 6; resume needs 4 more RUN cycles to reach the wrap.
    task automatic test_pause();
        int n;
        int w;
        w = ((5 - LAT) % 10 + 10) % 10;
        for (int i = 0; i < w; i++) tick();
        press_start();
        wait_running(1'b0, 20, n);
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("FAIL pause_latency: got %0d cycles, expected %0d", n, LAT + 1);
        end
        vectors++;
        if (dut.r_presc !== 4'd6) begin
            miscompares++;
            $display("FAIL pause_presc: presc=%0d expected 6", dut.r_presc);
        end
        for (int j = 1; j <= 30; j++) begin
            tick();
            vectors++;
            if (Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL pause_enable[%0d]: Enable=%b expected 0", j, Enable);
            end
        end
        press_start();
        wait_running(1'b1, 20, n);
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("FAIL resume_latency: got %0d cycles, expected %0d", n, LAT + 1);
        end
        for (int j = 1; j <= 4; j++) begin
            tick();
            vectors++;
            if (Enable !== (j == 4)) begin
                miscompares++;
                $display("FAIL resume_enable[%0d]: Enable=%b expected %b", j, Enable, (j == 4));
            end
        end
    endtask

    // Prescaler is 0 on entry; the press event lands in the cycle it holds 9.
    task automatic test_wrap_press();
        for (int i = 0; i < 9 - LAT; i++) tick();
        press_start();
        for (int i = 0; i < LAT + 1; i++) tick();
        vectors++;
        if (Enable !== 1'b1 || Running !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_press: Enable=%b Running=%b expected 1 0", Enable, Running);
        end
        vectors++;
        if (dut.r_state !== PAUSE) begin
            miscompares++;
            $display("FAIL wrap_press_state: state=%0d expected %0d", int'(dut.r_state), int'(PAUSE));
        end
        for (int j = 1; j <= 11; j++) begin
            tick();
            vectors++;
            if (Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_pause_enable[%0d]: Enable=%b expected 0", j, Enable);
            end
        end
        vectors++;
        if (dut.r_presc !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_pause_presc: presc=%0d expected 0", dut.r_presc);
        end
    endtask

    task automatic test_halt();
        int n;
        Halt = 1'b1;
        press_start();
        for (int i = 1; i <= LAT + 4; i++) begin
            tick();
            vectors++;
            if (Running !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_press[%0d]: Running=%b expected 0", i, Running);
            end
        end
        Halt = 1'b0;
        tick();
        vectors++;
        if (dut.r_state !== IDLE || dut.r_presc !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_press_state: state=%0d presc=%0d expected %0d 0",
                     int'(dut.r_state), dut.r_presc, int'(IDLE));
        end
        for (int i = 0; i < 12; i++) tick();
        press_start();
        wait_running(1'b1, 20, n);
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("FAIL halt_restart_latency: got %0d cycles, expected %0d", n, LAT + 1);
        end
        for (int i = 0; i < 9; i++) tick();
        Halt = 1'b1;
        tick();
        vectors++;
        if (Enable !== 1'b0 || Running !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_wrap: Enable=%b Running=%b expected 0 0", Enable, Running);
        end
        vectors++;
        if (dut.r_state !== IDLE || dut.r_presc !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_wrap_state: state=%0d presc=%0d expected %0d 0",
                     int'(dut.r_state), dut.r_presc, int'(IDLE));
        end
        Halt = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            tick();
            vectors++;
            if (Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_idle_enable[%0d]: Enable=%b expected 0", j, Enable);
            end
        end
    endtask

    // Without the filter every fall is a press: IDLE->RUN->PAUSE->RUN.
    task automatic test_bounce();
        logic seq [8];
        logic exp_run;
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SEC_TICK_DEBOUNCE_EN
        exp_run = 1'b0;
`else
        exp_run = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            KeyN = seq[i];
            tick();
        end
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (Running !== exp_run) begin
            miscompares++;
            $display("FAIL bounce_running: Running=%b expected %b", Running, exp_run);
        end
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
        vectors++;
        if (dut.r_state !== IDLE) begin
            miscompares++;
            $display("FAIL bounce_state: state=%0d expected %0d", int'(dut.r_state), int'(IDLE));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        press_start();
        for (int i = 0; i < 4; i++) tick();
        Reset    = 1'b1;
        key_hold = 0;
        #1;
        vectors++;
        if (Running !== 1'b0 || Enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_debounce: Running=%b Enable=%b expected 0 0", Running, Enable);
        end
        tick();
        Reset    = 1'b0;
        key_hold = HOLD;
        wait_running(1'b1, 20, n);
        vectors++;
        if (n !== LAT + 1) begin
            miscompares++;
            $display("FAIL reset_full_debounce: got %0d cycles, expected %0d", n, LAT + 1);
        end
        for (int i = 0; i < 5; i++) tick();
        Reset = 1'b1;
        #1;
        vectors++;
        if (Running !== 1'b0 || Enable !== 1'b0 || dut.r_presc !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_count: Running=%b Enable=%b presc=%0d expected 0 0 0",
                     Running, Enable, dut.r_presc);
        end
        tick();
        Reset    = 1'b0;
        KeyN     = 1'b1;
        key_hold = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            vectors++;
            if (Running !== 1'b0 || Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_quiet[%0d]: Running=%b Enable=%b expected 0 0", j, Running, Enable);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_run();
        test_pause();
        test_wrap_press();
        test_halt();
        test_bounce();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sec_tick_ctrl.md
SEC_TICK_CTRL -- requirements
Module: sec_tick_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, Enable pulse rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms), required stable period of the key.
REQ-004 SHALL have port Clock, input, 1, single system clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port KeyN, input, 1, raw asynchronous pushbutton, active-low: press = 0.
REQ-007 SHALL have port Halt, input, 1, synchronous, active-high: return to stopped.
REQ-008 SHALL have port Enable, output, 1, one-cycle tick strobe for the downstream BCD counter enable.
REQ-009 SHALL have port Running, output, 1, high while state = RUN.

Function
REQ-010 SHALL pass KeyN through a 2-flop synchronizer before any other use.
REQ-011 SHALL update the debounced key level only after the synchronized key differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 SHALL raise a one-cycle press event in the cycle after the debounced level falls 1->0; release raises no event.
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-014 SHALL go IDLE->RUN on a press event, and clear the prescaler on that transition.
REQ-015 SHALL go RUN->PAUSE and PAUSE->RUN on a press event; the prescaler holds its value in PAUSE, so tick phase is preserved on resume.
REQ-016 SHALL go from any state to IDLE when Halt=1, clear the prescaler, and give Halt priority over a coincident press event.
REQ-017 SHALL size the prescaler to $clog2(DIV) bits, increment it only in RUN, and wrap from DIV-1 to 0.
REQ-018 SHALL assert Enable, registered, for exactly one cycle per wrap: the cycle after the prescaler holds DIV-1 in RUN.
REQ-019 SHALL, when a press event and a wrap coincide in RUN, still emit that Enable pulse, then enter PAUSE.
REQ-020 SHALL drive Enable=0 in IDLE and PAUSE, except for the pulse due from the final RUN cycle.
REQ-021 SHALL, with Halt=1 in the same cycle as a wrap, suppress the pulse.

Reset
REQ-022 SHALL, on Reset=1 and asynchronously, set state=IDLE, prescaler=0, Enable=0, Running=0, synchronizer flops=1, debounced level=1, and debounce counter=0.
REQ-023 SHALL, on Reset asserted mid-count or mid-debounce, abandon the count with no Enable or press event after release until a new full debounce completes.

Configuration
REQ-024 SHALL, with macro SEC_TICK_DEBOUNCE_EN defined, implement debouncing per REQ-011.
REQ-025 SHALL, with SEC_TICK_DEBOUNCE_EN undefined, take the debounced level directly from the synchronizer output, so a press event occurs 3 cycles after KeyN falls; the debounce counter is not synthesized.

Structure
REQ-026 SHALL place the state enum typedef (IDLE/RUN/PAUSE) and the default constants CLK_HZ, TICK_HZ and DEBOUNCE_CYCLES in shared package tick_pkg.
REQ-027 SHALL implement synchronizer, debounce and press-event logic in sub-module key_debounce, instantiated once.

Verification (CLK_HZ=10, TICK_HZ=1 so DIV=10; DEBOUNCE_CYCLES=4; macro defined unless noted)
REQ-028 SHALL verify: Reset pulse, then KeyN low 8 cycles -> one press event, Running=1, and Enable pulses every 10 cycles, first pulse 10 cycles after entering RUN.
REQ-029 SHALL verify: KeyN bounce pattern 0,1,0,1 then 0 held 3 cycles -> no press event and state stays IDLE.
REQ-030 SHALL verify: press during RUN at prescaler=6, wait 30 cycles, press again -> no Enable while paused, and first pulse 4 cycles after resume.
REQ-031 SHALL verify: press event coincident with prescaler=DIV-1 -> one Enable pulse, then PAUSE with Running=0.
REQ-032 SHALL verify: Halt=1 coincident with press and with wrap -> state IDLE, prescaler 0, no Enable pulse.
REQ-033 SHALL verify: macro undefined, KeyN low 1 cycle -> press event 3 cycles later, IDLE->RUN.
